// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel datapath, framebuffer writer and VGA blocks.
package pixel_pkg;

  localparam logic [1:0] OP_DECIM = 2'b00;
  localparam logic [1:0] OP_MEDIA = 2'b01;
  localparam logic [1:0] OP_REP   = 2'b10;
  localparam logic [1:0] OP_VIZ   = 2'b11;

  localparam int unsigned DEF_FB_W  = 640;
  localparam int unsigned DEF_FB_H  = 480;
  localparam int unsigned DEF_SRC_W = 320;
  localparam int unsigned DEF_SRC_H = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RECV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Upscaling modes produce a 2x image; the others produce a 1/2 image.
  function automatic logic is_upscale(input logic [1:0] op);
    return (op == OP_REP) || (op == OP_VIZ);
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster x/y counters with an accumulated row base; yields the write address
// of the current pixel and flags the last pixel of the frame.
module raster_addr_gen
  import pixel_pkg::*;
#(
  parameter int unsigned FB_W = DEF_FB_W,
  parameter int unsigned FB_H = DEF_FB_H,
  parameter int unsigned AW   = 19,
  parameter int unsigned XW   = $clog2(FB_W + 1),
  parameter int unsigned YW   = $clog2(FB_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] out_w,
  input  logic [YW-1:0] out_h,
  input  logic [XW-1:0] ox,
  input  logic [YW-1:0] oy,
  output logic [AW-1:0] addr_c,
  output logic          last_c
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] row_base;

  assign addr_c = row_base + AW'(x);
  assign last_c = (x == out_w - XW'(1)) && (y == out_h - YW'(1));

  // Counter update; FB_W is an elaboration constant, so the load-time
  // product reduces to shifts and adds, and per-pixel addressing only adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= '0;
      y        <= '0;
      row_base <= AW'(oy) * AW'(FB_W) + AW'(ox);
    end else if (step) begin
      if (x == out_w - XW'(1)) begin
        x        <= '0;
        y        <= y + YW'(1);
        row_base <= row_base + AW'(FB_W);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Turns the processed pixel stream into centred framebuffer writes, with an
// optional clear pass, frame-done pulse and sticky protocol error flags.
module pixel_fb_writer
  import pixel_pkg::*;
#(
  parameter int unsigned FB_W  = DEF_FB_W,
  parameter int unsigned FB_H  = DEF_FB_H,
  parameter int unsigned SRC_W = DEF_SRC_W,
  parameter int unsigned SRC_H = DEF_SRC_H,
  parameter int unsigned AW    = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    opcode,
  input  logic          clear_en,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [7:0]    fb_data,
  output logic          busy,
  output logic          frame_done,
  output logic          err_drop,
  output logic          err_count
);

  localparam int unsigned XW        = $clog2(FB_W + 1);
  localparam int unsigned YW        = $clog2(FB_H + 1);
  localparam int unsigned DN_W      = SRC_W / 2;
  localparam int unsigned DN_H      = SRC_H / 2;
  localparam int unsigned UP_W      = SRC_W * 2;
  localparam int unsigned UP_H      = SRC_H * 2;
  localparam int unsigned DN_OX     = (FB_W - DN_W) / 2;
  localparam int unsigned DN_OY     = (FB_H - DN_H) / 2;
  localparam int unsigned UP_OX     = (FB_W - UP_W) / 2;
  localparam int unsigned UP_OY     = (FB_H - UP_H) / 2;
  localparam int unsigned LAST_ADDR = FB_W * FB_H - 1;

  state_t        state;
  logic          up_q;
  logic          rx_any;
  logic [AW-1:0] clr_addr;

  logic          sel_up_c;
  logic [XW-1:0] out_w_c;
  logic [YW-1:0] out_h_c;
  logic [XW-1:0] ox_c;
  logic [YW-1:0] oy_c;
  logic          step_c;
  logic [AW-1:0] addr_c;
  logic          last_c;

  // The raster is loaded on start, so geometry follows the incoming opcode then.
  assign sel_up_c = start ? is_upscale(opcode) : up_q;
  assign out_w_c  = sel_up_c ? XW'(UP_W)  : XW'(DN_W);
  assign out_h_c  = sel_up_c ? YW'(UP_H)  : YW'(DN_H);
  assign ox_c     = sel_up_c ? XW'(UP_OX) : XW'(DN_OX);
  assign oy_c     = sel_up_c ? YW'(UP_OY) : YW'(DN_OY);
  assign step_c   = (state == RECV) && pixel_valid && !start;

  raster_addr_gen #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .AW   (AW),
    .XW   (XW),
    .YW   (YW)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (step_c),
    .out_w  (out_w_c),
    .out_h  (out_h_c),
    .ox     (ox_c),
    .oy     (oy_c),
    .addr_c (addr_c),
    .last_c (last_c)
  );

  // Frame control FSM with registered write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      up_q       <= 1'b0;
      rx_any     <= 1'b0;
      clr_addr   <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
      err_count  <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (pixel_valid && (state != RECV)) err_drop <= 1'b1;
      if (start) begin
        if ((state == RECV) && rx_any) err_count <= 1'b1;
        up_q     <= is_upscale(opcode);
        rx_any   <= 1'b0;
        clr_addr <= '0;
        busy     <= 1'b1;
        state    <= clear_en ? CLEAR : RECV;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          CLEAR: begin
            fb_we   <= 1'b1;
            fb_addr <= clr_addr;
            fb_data <= '0;
            if (clr_addr == AW'(LAST_ADDR)) state <= RECV;
            else clr_addr <= clr_addr + AW'(1);
          end
          RECV: begin
            if (pixel_valid) begin
              fb_we   <= 1'b1;
              fb_addr <= addr_c;
              fb_data <= pixel_in;
              rx_any  <= 1'b1;
              if (last_c) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer on a scaled-down framebuffer geometry.
module tb_pixel_fb_writer;
  import pixel_pkg::*;

  localparam int unsigned FB_W    = 64;
  localparam int unsigned FB_H    = 48;
  localparam int unsigned SRC_W   = 32;
  localparam int unsigned SRC_H   = 24;
  localparam int unsigned AW      = 12;
  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int unsigned DN_W    = SRC_W / 2;
  localparam int unsigned DN_H    = SRC_H / 2;
  localparam int unsigned UP_W    = SRC_W * 2;
  localparam int unsigned UP_H    = SRC_H * 2;
  localparam int unsigned DN_BASE = ((FB_H - DN_H) / 2) * FB_W + (FB_W - DN_W) / 2;
  localparam int unsigned DN_LAST = DN_BASE + (DN_H - 1) * FB_W + DN_W - 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    opcode;
  logic          clear_en;
  logic [7:0]    pixel_in;
  logic          pixel_valid;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          busy;
  logic          frame_done;
  logic          err_drop;
  logic          err_count;

  wr_t           q[$];
  int            total = 0;
  int            bad = 0;
  int            done_seen = 0;
  logic [AW-1:0] last_done_addr = '0;

  pixel_fb_writer #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .clear_en    (clear_en),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_drop    (err_drop),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every presented write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (fb_we === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d", fb_addr, fb_data);
      end else begin
        e = q.pop_front();
        if (fb_addr !== e.addr || fb_data !== e.data || frame_done !== e.done) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0d done=%b required addr=%0d data=%0d done=%b",
                   fb_addr, fb_data, frame_done, e.addr, e.data, e.done);
        end
      end
    end else if (frame_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_without_write got frame_done=1 required 0");
    end
    if (frame_done === 1'b1) begin
      done_seen++;
      last_done_addr = fb_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] op, input logic clr);
    tick();
    start    = 1'b1;
    opcode   = op;
    clear_en = clr;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pixels(input logic up, input int n, input bit gaps, input int seed);
    int ow;
    int oh;
    int base;
    wr_t e;
    ow   = up ? int'(UP_W) : int'(DN_W);
    oh   = up ? int'(UP_H) : int'(DN_H);
    base = up ? 0 : int'(DN_BASE);
    for (int i = 0; i < n; i++) begin
      e.addr = AW'(base + (i / ow) * int'(FB_W) + (i % ow));
      e.data = 8'(i + seed);
      e.done = (i == ow * oh - 1);
      q.push_back(e);
      pixel_in    = e.data;
      pixel_valid = 1'b1;
      tick();
      pixel_valid = 1'b0;
      if (gaps) tick();
    end
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d required 0", q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total += 4;
    if (fb_we !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_we_done got we=%b done=%b required 0 0", fb_we, frame_done);
    end
    if (fb_addr !== '0 || fb_data !== '0) begin
      bad++; $display("FAIL reset_addr_data got addr=%0d data=%0d required 0 0", fb_addr, fb_data);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got %b required 0", busy);
    end
    if (err_drop !== 1'b0 || err_count !== 1'b0) begin
      bad++; $display("FAIL reset_err got drop=%b count=%b required 0 0", err_drop, err_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decim();
    int d0;
    d0 = done_seen;
    do_start(OP_DECIM, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL decim_busy_start got %b required 1", busy);
    end
    send_pixels(1'b0, int'(DN_W * DN_H), 1'b0, 0);
    wait_drain(50);
    total += 4;
    if (done_seen - d0 != 1) begin
      bad++; $display("FAIL decim_done_count got %0d required 1", done_seen - d0);
    end
    if (last_done_addr !== AW'(DN_LAST)) begin
      bad++; $display("FAIL decim_done_addr got %0d required %0d", last_done_addr, DN_LAST);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL decim_busy_end got %b required 0", busy);
    end
    if (err_drop !== 1'b0 || err_count !== 1'b0) begin
      bad++; $display("FAIL decim_err got drop=%b count=%b required 0 0", err_drop, err_count);
    end
  endtask

  task automatic test_rep_gaps();
    int d0;
    d0 = done_seen;
    do_start(OP_REP, 1'b0);
    send_pixels(1'b1, int'(UP_W * UP_H), 1'b1, 3);
    wait_drain(50);
    total += 3;
    if (done_seen - d0 != 1) begin
      bad++; $display("FAIL rep_done_count got %0d required 1", done_seen - d0);
    end
    if (last_done_addr !== AW'(FB_SIZE - 1)) begin
      bad++; $display("FAIL rep_done_addr got %0d required %0d", last_done_addr, FB_SIZE - 1);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rep_busy_end got %b required 0", busy);
    end
  endtask

  task automatic test_clear();
    int d0;
    wr_t e;
    d0 = done_seen;
    for (int a = 0; a < int'(FB_SIZE); a++) begin
      e.addr = AW'(a);
      e.data = 8'h00;
      e.done = 1'b0;
      q.push_back(e);
    end
    do_start(OP_MEDIA, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    pixel_valid = 1'b1;
    pixel_in    = 8'h5A;
    tick();
    pixel_valid = 1'b0;
    wait_drain(int'(FB_SIZE) + 20);
    total += 2;
    if (err_drop !== 1'b1) begin
      bad++; $display("FAIL clear_err_drop got %b required 1", err_drop);
    end
    if (busy !== 1'b1) begin
      bad++; $display("FAIL clear_busy_recv got %b required 1", busy);
    end
    send_pixels(1'b0, int'(DN_W * DN_H), 1'b0, 9);
    wait_drain(50);
    total++;
    if (done_seen - d0 != 1) begin
      bad++; $display("FAIL clear_done_count got %0d required 1", done_seen - d0);
    end
  endtask

  task automatic test_abort();
    int d0;
    do_start(OP_VIZ, 1'b0);
    send_pixels(1'b1, 1000, 1'b0, 5);
    d0 = done_seen;
    do_start(OP_DECIM, 1'b0);
    total += 2;
    if (err_count !== 1'b1) begin
      bad++; $display("FAIL abort_err_count got %b required 1", err_count);
    end
    if (done_seen != d0) begin
      bad++; $display("FAIL abort_spurious_done got %0d required 0", done_seen - d0);
    end
    send_pixels(1'b0, int'(DN_W * DN_H), 1'b0, 1);
    wait_drain(50);
    total++;
    if (done_seen - d0 != 1) begin
      bad++; $display("FAIL abort_next_done got %0d required 1", done_seen - d0);
    end
  endtask

  task automatic test_reset_mid_recv();
    int d0;
    do_start(OP_DECIM, 1'b0);
    send_pixels(1'b0, 10, 1'b0, 0);
    rst = 1'b1;
    #1;
    q.delete();
    total += 3;
    if (fb_we !== 1'b0 || fb_addr !== '0 || fb_data !== '0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_port got we=%b addr=%0d data=%0d done=%b required 0 0 0 0",
                      fb_we, fb_addr, fb_data, frame_done);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy got %b required 0", busy);
    end
    if (err_drop !== 1'b0 || err_count !== 1'b0) begin
      bad++; $display("FAIL rstmid_err got drop=%b count=%b required 0 0", err_drop, err_count);
    end
    for (int k = 0; k < 3; k++) begin
      pixel_valid = 1'b1;
      tick();
      total++;
      if (fb_we !== 1'b0) begin
        bad++; $display("FAIL rstmid_write_in_reset got %b required 0", fb_we);
      end
    end
    pixel_valid = 1'b0;
    rst = 1'b0;
    d0 = done_seen;
    do_start(OP_DECIM, 1'b0);
    send_pixels(1'b0, int'(DN_W * DN_H), 1'b0, 0);
    wait_drain(50);
    total++;
    if (done_seen - d0 != 1) begin
      bad++; $display("FAIL rstmid_done_count got %0d required 1", done_seen - d0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    opcode      = 2'b00;
    clear_en    = 1'b0;
    pixel_in    = 8'h00;
    pixel_valid = 1'b0;
    test_reset();
    test_decim();
    test_rep_gaps();
    test_clear();
    test_abort();
    test_reset_mid_recv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
